// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 divider slice.
//   - field widths and exponent bias of IEEE-754 single precision
//   - canonical result constants (quiet NaN, +infinity)
//   - fixed latency of the divider and the number of quotient bits it produces
//   - FSM state and special-case classification enums
package fp32_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int BIAS      = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Edges from the start-sampling edge to the edge that raises out_done.
    // Set by the FSM shape (1 SETUP + 27 DIV + 1 ROUND), not tunable.
    localparam int LATENCY   = 29;
    localparam int DIV_STEPS = 27;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DIV,
        ROUND
    } state_t;

    // Outcome of operand classification; SP_NONE means the normal datapath
    // result is used.
    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

endpackage

// File: rtl/fp32_div_if.sv
// Start/done handshake bundle of the divider.
//   in_start   request a division (honoured only while out_busy is low)
//   in_numA    dividend, binary32
//   in_numB    divisor, binary32
//   out_result quotient, binary32, valid while out_done is high and held after
//   out_busy   operation in flight
//   out_done   one-cycle completion pulse
// master: the requester; slave: the divider.
interface fp32_div_if;
    logic        in_start;
    logic [31:0] in_numA;
    logic [31:0] in_numB;
    logic [31:0] out_result;
    logic        out_busy;
    logic        out_done;

    modport master (
        output in_start, in_numA, in_numB,
        input  out_result, out_busy, out_done
    );

    modport slave (
        input  in_start, in_numA, in_numB,
        output out_result, out_busy, out_done
    );
endinterface

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into its fields and classifies it.
//   num      binary32 operand
//   sign     sign bit
//   expo     biased exponent
//   sig      significand with the hidden one restored ({1, frac})
//   is_zero  exponent 0: zero or subnormal, both treated as zero
//   is_inf   exponent all ones, fraction zero
//   is_nan   exponent all ones, fraction non-zero
// Purely combinational.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       num,
    output logic              sign,
    output logic [EXP_W-1:0]  expo,
    output logic [FRAC_W:0]   sig,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan
);

    logic [FRAC_W-1:0] frac;

    assign sign = num[31];
    assign expo = num[30:23];
    assign frac = num[22:0];

    // The hidden one is always set; for exponent 0 the significand is
    // meaningless because the operand is routed through the zero special case.
    assign sig     = {1'b1, frac};
    assign is_zero = (expo == '0);
    assign is_inf  = (expo == '1) && (frac == '0);
    assign is_nan  = (expo == '1) && (frac != '0);

endmodule

// File: rtl/fp32_div.sv
// Multi-cycle binary32 divider: out_result = in_numA / in_numB.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts an operation without done
//   bus   fp32_div_if slave port (start/operands in, result/busy/done out)
// Restoring divider producing one quotient bit per DIV cycle, round to
// nearest even, flush-to-zero on inputs and outputs. Latency is LATENCY
// edges for every operand class, special cases included.
module fp32_div
    import fp32_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    fp32_div_if.slave bus
);

    state_t state_reg, state_next;

    logic [31:0]        a_reg, b_reg;
    logic [4:0]         cnt_reg;
    logic [23:0]        div_reg;
    logic [25:0]        rem_reg;
    logic [26:0]        q_reg;
    logic signed [9:0]  exp_reg;
    logic               sign_reg;
    special_t           spec_reg;
    logic [31:0]        result_reg;
    logic               done_reg;

    // Operand fields, decoded from the latched operands during SETUP.
    logic              a_sign, b_sign;
    logic [EXP_W-1:0]  a_exp, b_exp;
    logic [FRAC_W:0]   a_sig, b_sig;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    fp32_unpack u_unpack_a (
        .num     (a_reg),
        .sign    (a_sign),
        .expo    (a_exp),
        .sig     (a_sig),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan)
    );

    fp32_unpack u_unpack_b (
        .num     (b_reg),
        .sign    (b_sign),
        .expo    (b_exp),
        .sig     (b_sig),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan)
    );

    // Classification; the order of the tests is the priority.
    special_t spec_next;
    always_comb begin
        spec_next = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            spec_next = SP_NAN;
        else if (a_inf || b_zero)
            spec_next = SP_INF;
        else if (a_zero || b_inf)
            spec_next = SP_ZERO;
    end

    // One restoring step: subtract the divisor when it fits.
    logic        rem_ge;
    logic [25:0] rem_sub;
    always_comb begin
        rem_ge  = (rem_reg >= {2'b00, div_reg});
        rem_sub = rem_ge ? (rem_reg - {2'b00, div_reg}) : rem_reg;
    end

    // Normalise and round the finished quotient. rem_reg holds the final
    // remainder shifted left once, which does not change whether it is zero.
    // The leading one of the selected 24-bit mantissa is implicit, so only the
    // 23 fraction bits are carried; an all-ones fraction that rounds up wraps
    // to zero and bumps the exponent, giving mantissa 0x800000.
    logic [22:0]       frac_pre, frac_fin;
    logic              guard, sticky, round_up, carry;
    logic signed [9:0] exp_pre, exp_fin;
    logic [31:0]       norm_word, result_next;
    always_comb begin
        if (q_reg[26]) begin
            frac_pre = q_reg[25:3];
            guard    = q_reg[2];
            sticky   = (|q_reg[1:0]) | (|rem_reg);
            exp_pre  = exp_reg;
        end else begin
            frac_pre = q_reg[24:2];
            guard    = q_reg[1];
            sticky   = q_reg[0] | (|rem_reg);
            exp_pre  = exp_reg - 10'sd1;
        end
        round_up = guard & (sticky | frac_pre[0]);
        carry    = round_up & (&frac_pre);
        frac_fin = frac_pre + {22'd0, round_up};
        exp_fin  = carry ? (exp_pre + 10'sd1) : exp_pre;

        if (exp_fin >= 10'sd255)
            norm_word = {sign_reg, POS_INF[30:0]};
        else if (exp_fin <= 10'sd0)
            norm_word = {sign_reg, 31'd0};
        else
            norm_word = {sign_reg, exp_fin[7:0], frac_fin};

        case (spec_reg)
            SP_NAN:  result_next = QNAN;
            SP_INF:  result_next = {sign_reg, POS_INF[30:0]};
            SP_ZERO: result_next = {sign_reg, 31'd0};
            default: result_next = norm_word;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_start) state_next = SETUP;
            SETUP:   state_next = DIV;
            DIV:     if (cnt_reg == 5'd0) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= 32'd0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ROUND);
            if (state_reg == ROUND)
                result_reg <= result_next;
        end
    end

    // Datapath registers; only meaningful between SETUP and ROUND, so they
    // need no reset.
    always_ff @(posedge clk) begin
        case (state_reg)
            IDLE: begin
                if (bus.in_start) begin
                    a_reg <= bus.in_numA;
                    b_reg <= bus.in_numB;
                end
            end
            SETUP: begin
                sign_reg <= a_sign ^ b_sign;
                spec_reg <= spec_next;
                exp_reg  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                            + $signed(10'(BIAS));
                div_reg  <= b_sig;
                rem_reg  <= {2'b00, a_sig};
                q_reg    <= '0;
                cnt_reg  <= 5'(DIV_STEPS - 1);
            end
            DIV: begin
                q_reg   <= {q_reg[25:0], rem_ge};
                rem_reg <= rem_sub << 1;
                cnt_reg <= cnt_reg - 5'd1;
            end
            default: ;
        endcase
    end

    assign bus.out_result = result_reg;
    assign bus.out_busy   = (state_reg != IDLE);
    assign bus.out_done   = done_reg;

endmodule

// File: tb/tb_fp32_div.sv
// Self-checking bench for fp32_div: directed vectors, special cases,
// handshake corner cases and a random sweep against a reference model.
module tb_fp32_div;
    import fp32_pkg::*;

    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp32_div_if bus ();

    fp32_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] expq[$];

    // Independent reference: 64-bit integer quotient with wider precision,
    // then round to nearest even on the discarded bits plus exact remainder.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, e, sh;
        bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rem_nz;
        longint ma, mb, num, q, mant, lowb, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == 255) && (a[22:0] == 23'd0);
        b_inf  = (eb == 255) && (b[22:0] == 23'd0);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            return 32'h7FC0_0000;
        if (a_inf || b_zero)
            return {s, 8'hFF, 23'd0};
        if (a_zero || b_inf)
            return {s, 31'd0};
        ma  = longint'({1'b1, a[22:0]});
        mb  = longint'({1'b1, b[22:0]});
        num = ma << 38;
        q   = num / mb;
        rem_nz = (num % mb) != 0;
        e = ea - eb + 127;
        if (q >= (longint'(1) << 38)) begin
            sh = 15;
        end else begin
            sh = 14;
            e  = e - 1;
        end
        mant = q >> sh;
        lowb = q & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        if (lowb > half || (lowb == half && (rem_nz || mant[0])))
            mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    // Drives one start, pushes its expected result and waits for done.
    // cyc counts edges after the accepting edge; poke_at >= 0 re-asserts
    // in_start with other operands for one cycle at that point.
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] expect_v, input int poke_at,
                            output logic [31:0] res, output int cyc,
                            output int busy_low);
        bus.in_numA  = a;
        bus.in_numB  = b;
        bus.in_start = 1'b1;
        expq.push_back(expect_v);
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        cyc = 0;
        busy_low = 0;
        while (bus.out_done !== 1'b1 && cyc < TIMEOUT) begin
            if (bus.out_busy !== 1'b1) busy_low++;
            if (cyc == poke_at) begin
                bus.in_numA  = 32'h4080_0000;
                bus.in_numB  = 32'h3F80_0000;
                bus.in_start = 1'b1;
            end else begin
                bus.in_start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_start = 1'b0;
        res = bus.out_result;
        $display("op %h / %h -> %h (expect %h) after %0d edges", a, b, res, expect_v, cyc);
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.out_result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 00000000", bus.out_result);
        end
        vectors++;
        if (bus.out_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", bus.out_busy);
        end
        vectors++;
        if (bus.out_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", bus.out_done);
        end
    endtask

    task automatic test_basic();
        logic [31:0] va[3], vb[3], ve[3];
        logic [31:0] res, e;
        int cyc, bl;
        va = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000};
        vb = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000};
        ve = '{32'h4040_0000, 32'h3EAA_AAAB, 32'hBF00_0000};
        for (int i = 0; i < 3; i++) begin
            drive_op(va[i], vb[i], ve[i], -1, res, cyc, bl);
            e = expq.pop_front();
            vectors++;
            if (res !== e) begin
                miscompares++;
                $display("FAIL basic_result[%0d]: got %h want %h", i, res, e);
            end
            vectors++;
            if (cyc !== LATENCY) begin
                miscompares++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, cyc, LATENCY);
            end
            vectors++;
            if (bl !== 0) begin
                miscompares++;
                $display("FAIL basic_busy[%0d]: busy low %0d cycles want 0", i, bl);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[8], vb[8], ve[8];
        logic [31:0] res, e;
        int cyc, bl;
        va = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0001,
               32'h4000_0000, 32'h7F7F_FFFF, 32'h0080_0000, 32'h0000_0001};
        vb = '{32'h8000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h3F80_0000,
               32'h7F80_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000};
        ve = '{32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
               32'h0000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            drive_op(va[i], vb[i], ve[i], -1, res, cyc, bl);
            e = expq.pop_front();
            vectors++;
            if (res !== e) begin
                miscompares++;
                $display("FAIL special_result[%0d]: got %h want %h", i, res, e);
            end
            vectors++;
            if (cyc !== LATENCY) begin
                miscompares++;
                $display("FAIL special_latency[%0d]: got %0d want %0d", i, cyc, LATENCY);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] res, e;
        int cyc, bl;
        drive_op(32'h4120_0000, 32'h4080_0000, 32'h4020_0000, -1, res, cyc, bl);
        e = expq.pop_front();
        vectors++;
        if (res !== e) begin
            miscompares++;
            $display("FAIL hold_result: got %h want %h", res, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.out_result !== e || bus.out_done !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: got %h done %b want %h done 0",
                         i, bus.out_result, bus.out_done, e);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res, e;
        int cyc, bl;
        drive_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5, res, cyc, bl);
        e = expq.pop_front();
        vectors++;
        if (res !== e) begin
            miscompares++;
            $display("FAIL ignore_result: got %h want %h", res, e);
        end
        vectors++;
        if (cyc !== LATENCY) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d want %0d", cyc, LATENCY);
        end
        // The stray start must not have launched a second operation.
        @(posedge clk); #1;
        vectors++;
        if (bus.out_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_idle: busy %b want 0", bus.out_busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] res, e;
        int cyc, bl, dones;
        bus.in_numA  = 32'h40C0_0000;
        bus.in_numB  = 32'h4000_0000;
        bus.in_start = 1'b1;
        expq.push_back(32'h4040_0000);
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(expq.pop_front());
        $display("op 40c00000 / 40000000 aborted by reset: result %h busy %b done %b",
                 bus.out_result, bus.out_busy, bus.out_done);
        vectors++;
        if (bus.out_result !== 32'd0 || bus.out_busy !== 1'b0 || bus.out_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h busy %b done %b want 00000000 0 0",
                     bus.out_result, bus.out_busy, bus.out_done);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses want 0", dones);
        end
        drive_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, -1, res, cyc, bl);
        e = expq.pop_front();
        vectors++;
        if (res !== e || cyc !== LATENCY) begin
            miscompares++;
            $display("FAIL after_abort: got %h in %0d want %h in %0d", res, cyc, e, LATENCY);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, e;
        int cyc, bl;
        drive_op(32'hC1A0_0000, 32'h40A0_0000, 32'hC080_0000, -1, res, cyc, bl);
        e = expq.pop_front();
        vectors++;
        if (res !== e) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want %h", res, e);
        end
        // Issued in the out_done cycle, so sampled by the very next edge.
        drive_op(32'h4049_0FDB, 32'h402D_F854, ref_div(32'h4049_0FDB, 32'h402D_F854),
                 -1, res, cyc, bl);
        e = expq.pop_front();
        vectors++;
        if (res !== e || cyc !== LATENCY) begin
            miscompares++;
            $display("FAIL b2b_second: got %h in %0d want %h in %0d", res, cyc, e, LATENCY);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, e;
        int cyc, bl;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 3) begin
                a[30:23] = 8'($urandom_range(1, 254));
                b[30:23] = 8'($urandom_range(1, 254));
            end else begin
                a[30:23] = 8'($urandom_range(90, 164));
                b[30:23] = 8'($urandom_range(90, 164));
            end
            drive_op(a, b, ref_div(a, b), -1, res, cyc, bl);
            e = expq.pop_front();
            vectors++;
            if (res !== e) begin
                miscompares++;
                $display("FAIL random[%0d] %h/%h: got %h want %h", i, a, b, res, e);
            end
        end
    endtask

    initial begin
        bus.in_start = 1'b0;
        bus.in_numA  = 32'd0;
        bus.in_numB  = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_specials();
        test_hold();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
